// File: rtl/imm_decode_queue.sv
// Immediate decoder feeding a DEPTH-entry FIFO with valid/ready handshakes on both sides.
// Optional macro IMM_CSR_ZIMM_EN adds out_zimm and the zero-extended CSR zimm immediate.
module imm_decode_queue #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_instr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_instr,
    output logic [XLEN-1:0]        out_imm,
    output logic [2:0]             out_type,
    output logic                   out_illegal,
`ifdef IMM_CSR_ZIMM_EN
    output logic [4:0]             out_zimm,
`endif
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [2:0] T_R   = 3'd0;
    localparam logic [2:0] T_I   = 3'd1;
    localparam logic [2:0] T_S   = 3'd2;
    localparam logic [2:0] T_B   = 3'd3;
    localparam logic [2:0] T_U   = 3'd4;
    localparam logic [2:0] T_J   = 3'd5;
    localparam logic [2:0] T_ILL = 3'd7;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        logic signed [XLEN-1:0] s;
        s = XLEN'($signed(v));
        return s;
    endfunction

    logic [6:0]      opcode;
    logic [2:0]      dec_type;
    logic            dec_ill;
    logic [31:0]     imm32;
    logic [XLEN-1:0] dec_imm;
`ifdef IMM_CSR_ZIMM_EN
    logic [4:0]      dec_zimm;
`endif

    always_comb begin
        opcode   = in_instr[6:0];
        dec_type = T_ILL;
        dec_ill  = 1'b0;
        imm32    = '0;
        case (opcode)
            7'b0000011, 7'b0010011, 7'b1100111, 7'b0001111, 7'b1110011: begin
                dec_type = T_I;
                imm32    = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            7'b0011011: begin
                if (XLEN == 64) begin
                    dec_type = T_I;
                    imm32    = {{20{in_instr[31]}}, in_instr[31:20]};
                end else begin
                    dec_ill = 1'b1;
                end
            end
            7'b0100011: begin
                dec_type = T_S;
                imm32    = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            end
            7'b1100011: begin
                dec_type = T_B;
                imm32    = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                            in_instr[30:25], in_instr[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                dec_type = T_U;
                imm32    = {in_instr[31:12], 12'b0};
            end
            7'b1101111: begin
                dec_type = T_J;
                imm32    = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                            in_instr[20], in_instr[30:21], 1'b0};
            end
            7'b0110011: dec_type = T_R;
            7'b0111011: begin
                if (XLEN == 64) dec_type = T_R;
                else            dec_ill  = 1'b1;
            end
            default: dec_ill = 1'b1;
        endcase
        dec_imm = sext32(imm32);
`ifdef IMM_CSR_ZIMM_EN
        dec_zimm = '0;
        // CSR*I forms carry an unsigned 5-bit immediate in the rs1 field
        if (opcode == 7'b1110011 && in_instr[14]) begin
            dec_zimm = in_instr[19:15];
            dec_imm  = XLEN'(in_instr[19:15]);
        end
`endif
    end

    logic [PW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     instr_mem_q [DEPTH];
    logic [31:0]     instr_mem_d [DEPTH];
    logic [XLEN-1:0] imm_mem_q   [DEPTH];
    logic [XLEN-1:0] imm_mem_d   [DEPTH];
    logic [2:0]      type_mem_q  [DEPTH];
    logic [2:0]      type_mem_d  [DEPTH];
    logic            ill_mem_q   [DEPTH];
    logic            ill_mem_d   [DEPTH];
`ifdef IMM_CSR_ZIMM_EN
    logic [4:0]      zimm_mem_q  [DEPTH];
    logic [4:0]      zimm_mem_d  [DEPTH];
`endif
    logic            push, pop;

    assign in_ready  = (count_q < CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign count     = count_q;

    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        instr_mem_d = instr_mem_q;
        imm_mem_d   = imm_mem_q;
        type_mem_d  = type_mem_q;
        ill_mem_d   = ill_mem_q;
`ifdef IMM_CSR_ZIMM_EN
        zimm_mem_d  = zimm_mem_q;
`endif
        if (push) begin
            instr_mem_d[wptr_q] = in_instr;
            imm_mem_d[wptr_q]   = dec_imm;
            type_mem_d[wptr_q]  = dec_type;
            ill_mem_d[wptr_q]   = dec_ill;
`ifdef IMM_CSR_ZIMM_EN
            zimm_mem_d[wptr_q]  = dec_zimm;
`endif
            wptr_d = wptr_q + PW'(1);
        end
        if (pop) rptr_d = rptr_q + PW'(1);
        if (push && !pop)      count_d = count_q + CW'(1);
        else if (pop && !push) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            instr_mem_q <= '{default: '0};
            imm_mem_q   <= '{default: '0};
            type_mem_q  <= '{default: '0};
            ill_mem_q   <= '{default: '0};
`ifdef IMM_CSR_ZIMM_EN
            zimm_mem_q  <= '{default: '0};
`endif
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            instr_mem_q <= instr_mem_d;
            imm_mem_q   <= imm_mem_d;
            type_mem_q  <= type_mem_d;
            ill_mem_q   <= ill_mem_d;
`ifdef IMM_CSR_ZIMM_EN
            zimm_mem_q  <= zimm_mem_d;
`endif
        end
    end

    // Head fields read as zero whenever the queue is empty
    assign out_instr   = out_valid ? instr_mem_q[rptr_q] : '0;
    assign out_imm     = out_valid ? imm_mem_q[rptr_q]   : '0;
    assign out_type    = out_valid ? type_mem_q[rptr_q]  : '0;
    assign out_illegal = out_valid ? ill_mem_q[rptr_q]   : 1'b0;
`ifdef IMM_CSR_ZIMM_EN
    assign out_zimm    = out_valid ? zimm_mem_q[rptr_q]  : '0;
`endif
endmodule

// File: doc/imm_decode_queue.md
Name: imm_decode_queue

Overview:
- Parametrised successor to the core's combinational immediate generator.
- Accepts 32-bit RV32I/RV64I instruction words over a valid/ready handshake and classifies the instruction format.
- Produces the sign-extended immediate at XLEN bits.
- Buffers results in a DEPTH-entry FIFO so fetch and execute stages decouple under back-pressure.

Parameters:
- XLEN, 64, immediate/output width; legal values 32 or 64.
- DEPTH, 2, FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  instruction presented.
- in_ready  output  1  block can accept this cycle.
- in_instr  input  32  instruction word.
- out_valid  output  1  head entry valid.
- out_ready  input  1  consumer takes head this cycle.
- out_instr  output  32  instruction of head entry.
- out_imm  output  XLEN  sign-extended immediate of head entry.
- out_type  output  3  format code of head entry.
- out_illegal  output  1  head opcode unsupported.
- count  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Push occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready.
- in_ready = (count < DEPTH). It is derived from registered count only and never depends on out_ready, so there is no same-cycle pass-through when full.
- out_valid = (count != 0).
- Decode is combinational on in_instr. The decoded fields are written into the FIFO at push.
- Latency: an entry pushed in cycle N is visible on out_* in cycle N+1 at the earliest.
- Simultaneous push and pop: both happen and count is unchanged. This is legal at any occupancy 1..DEPTH-1, and also at DEPTH? No: at DEPTH, push is blocked.
- Read and write pointers are $clog2(DEPTH) bits and wrap naturally.
- When count == 0, out_instr, out_imm, out_type and out_illegal are driven to 0.
- Reset (async, any time, including mid-burst) clears both pointers, count and all storage to 0. Consequently out_valid = 0, in_ready = 1 and all out_* = 0. Entries in flight are discarded.
- out_type codes: 0 R/none, 1 I, 2 S, 3 B, 4 U, 5 J, 7 illegal.
- Opcode map:
  - 0000011 LOAD, 0010011 OP-IMM, 1100111 JALR, 0001111 MISC-MEM, 1110011 SYSTEM → I.
  - 0011011 OP-IMM-32 → I, only when XLEN = 64; otherwise illegal.
  - 0100011 → S.
  - 1100011 → B.
  - 0110111, 0010111 → U.
  - 1101111 → J.
  - 0110011 → R, imm 0.
  - 0111011 → R, only when XLEN = 64; otherwise illegal.
  - Any other opcode → type 7, out_illegal = 1, imm 0.
- Immediates, each sign-extended from instr[31] to XLEN:
  - I = instr[31:20].
  - S = {instr[31:25], instr[11:7]}.
  - B = {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U = {instr[31:12], 12'b0}.
  - J = {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- Illegal instructions are still queued, never dropped.

Optional Feature:
- Macro: IMM_CSR_ZIMM_EN.
- Defined:
  - Adds port out_zimm (output, 5 bits).
  - For SYSTEM instructions with funct3[2] = 1 (CSRRWI/CSRRSI/CSRRCI), out_imm = zero-extended instr[19:15] and out_zimm = instr[19:15]. out_type stays 1.
  - For all other instructions, out_zimm = 0.
- Undefined:
  - No out_zimm port.
  - All SYSTEM instructions produce the I immediate (CSR address sign-extended).

Test Plan:
- XLEN=64: push 0xFFF00093 (addi x1,x0,-1) with out_ready = 1 → next cycle out_valid = 1, out_imm = 0xFFFFFFFFFFFFFFFF, out_type = 1, count = 1.
- Push in sequence:
  - 0xFE112E23 (sw) → imm 0xFFFFFFFFFFFFFFFC, type 2.
  - 0xFE000CE3 (beq) → imm 0xFFFFFFFFFFFFFFF8, type 3.
  - 0xFFDFF06F (jal) → imm 0xFFFFFFFFFFFFFFFC, type 5.
- 0x123452B7 → imm 0x0000000012345000, type 4. 0x800002B7 → imm 0xFFFFFFFF80000000 at XLEN=64 and 0x80000000 at XLEN=32.
- XLEN=32: 0x0010009B (OP-IMM-32) → type 7, out_illegal = 1, imm 0. Also 0x0000007F → type 7 at either XLEN.
- Back-pressure, DEPTH=2, out_ready = 0:
  - After 2 pushes, in_ready = 0 and count = 2, and a third in_valid is not accepted.
  - Raise out_ready for 1 cycle → count = 1 and in_ready = 1.
  - Simultaneous push and pop holds count = 1 and preserves FIFO order.
- Assert rst asynchronously with count = 2 mid-cycle → immediately out_valid = 0, count = 0, in_ready = 1, out_imm = 0. With IMM_CSR_ZIMM_EN, 0x3401D073 (csrrwi) → out_imm = 3, out_zimm = 3.
